ultrasonic_echo_emulator: RTL and testbench
===========================================

// Module: ultrasonic_echo_emulator
// PURPOSE
//  HC-SR04 responder model. Accepts the trig pulse from the ultrasonic ranging
//  controller and answers with an echo pulse whose width encodes a programmed
//  distance (58 us/cm). Used as a board-level stand-in for the physical sensor
//  so the ranging controller and its 7-seg readout can be exercised without one.
// PARAMETERS
//  TRIG_MIN_TICKS    500        min synced trig-high cycles for a valid trigger (10 us @50 MHz)
//  BURST_DELAY_TICKS 12500      cycles from accepted trig fall to echo rise (250 us)
//  TICKS_PER_CM      2900       echo-high cycles per cm (58 us @50 MHz)
//  MAX_CM            400        largest in-range distance
//  TIMEOUT_TICKS     1900000    echo width for no-object / out-of-range (38 ms)
//  HOLDOFF_TICKS     500000     dead time after echo fall before the next trigger (10 ms)
// PORTS
//  clk       in   1  system clock, 50 MHz
//  rst       in   1  synchronous reset, active high
//  en        in   1  1 = respond to triggers; sampled only in IDLE
//  trig      in   1  trigger from controller, asynchronous to clk
//  dist_cm   in   9  emulated distance in cm; sampled on accepted trig fall
//  echo      out  1  echo pulse to controller
//  busy      out  1  1 in any state other than IDLE
//  trig_err  out  1  1-cycle pulse: trigger rejected (too short)
//  last_cm   out  9  distance latched for the current/last echo
// BEHAVIOUR
//  - trig passes through a 2-FF synchronizer (trig_s); all edges are detected on trig_s.
//  - Reset: echo=0, busy=0, trig_err=0, last_cm=0, state=IDLE, counters=0, sync FFs=0.
//  - Counter width: CW = $clog2(TIMEOUT_TICKS+1) (21 b). Echo width is computed as
//    dist_cm*TICKS_PER_CM in CW bits; max in-range product is 1160000, so no overflow.
//  - FSM:
//    IDLE: leave only on a trig_s rising edge with en=1 -> TRIG_HI, cnt=1.
//          If trig_s is already high on IDLE entry, wait for a fresh rising edge.
//    TRIG_HI: cnt++ while trig_s=1 (saturate at TRIG_MIN_TICKS). On trig_s fall:
//          cnt>=TRIG_MIN_TICKS -> latch last_cm=dist_cm, compute width, -> BURST, cnt=0;
//          else trig_err=1 for that one cycle -> IDLE.
//    BURST: echo=0; after BURST_DELAY_TICKS cycles -> ECHO. echo rises exactly
//          BURST_DELAY_TICKS cycles after the cycle the trig_s fall was detected.
//    ECHO: echo=1 for exactly W cycles, then echo=0 -> HOLDOFF.
//          W = last_cm*TICKS_PER_CM if 1<=last_cm<=MAX_CM; W = TIMEOUT_TICKS
//          if last_cm==0 or last_cm>MAX_CM (no object).
//    HOLDOFF: HOLDOFF_TICKS cycles -> IDLE. trig activity is ignored here.
//  - trig edges in BURST/ECHO/HOLDOFF are ignored, no trig_err. dist_cm changes
//    after latching have no effect on the echo in progress.
//  - en dropping mid-cycle does not abort; the current cycle completes.
//  - rst asserted in any state: on the next edge echo=0 and state=IDLE. No partial
//    echo continues.
//  - busy is registered: 1 from the cycle after the trig_s rise through the last
//    HOLDOFF cycle.
// CONFIGURATION
//  ECHO_JITTER_EN defined: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 8'hA5
//   at reset, advances once per accepted trigger; W += lfsr[3:0] (0..15 cycles)
//   for in-range distances only. The timeout width is never jittered.
//  Undefined: W is exact as above; no LFSR logic is built.
// TESTING (macro undefined unless stated)
//  1. dist_cm=100, trig high 500 cyc -> echo rises 12500 cyc after the sync'd fall,
//     stays high exactly 290000 cyc; last_cm=100.
//  2. trig high 499 cyc -> trig_err pulses once, echo stays 0, busy returns to 0.
//  3. dist_cm=0, then dist_cm=401 -> echo high 1900000 cyc each time.
//  4. second trig during ECHO and HOLDOFF -> ignored; next valid trig after
//     HOLDOFF -> new echo.
//  5. rst during ECHO -> echo=0 next cycle, busy=0, last_cm=0; trig held high
//     across reset -> no response until trig falls and rises again.
//  6. ECHO_JITTER_EN, dist_cm=1, 3 triggers -> widths 2900+lfsr[3:0] matching the
//     reference LFSR sequence from seed 8'hA5.

Source files
------------

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04 responder: validates trig pulse width, waits the burst delay, then drives echo for dist_cm*TICKS_PER_CM cycles.
// Latency: echo rises BURST_DELAY_TICKS cycles after the synchronised trig fall; no backpressure, triggers outside IDLE are dropped.
// Optional ECHO_JITTER_EN adds 0..15 cycles of LFSR jitter to in-range echo widths.
module ultrasonic_echo_emulator #(
    parameter int TRIG_MIN_TICKS    = 500,
    parameter int BURST_DELAY_TICKS = 12500,
    parameter int TICKS_PER_CM      = 2900,
    parameter int MAX_CM            = 400,
    parameter int TIMEOUT_TICKS     = 1900000,
    parameter int HOLDOFF_TICKS     = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       trig,
    input  logic [8:0] dist_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_err,
    output logic [8:0] last_cm
);

    localparam int CW = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [CW-1:0] TRIG_MIN_C   = CW'(TRIG_MIN_TICKS);
    // BURST is entered with cnt=0 one cycle after the fall is seen, so the
    // last BURST cycle is at cnt=D-2 (needs BURST_DELAY_TICKS >= 2).
    localparam logic [CW-1:0] BURST_LAST_C = CW'(BURST_DELAY_TICKS - 2);
    localparam logic [CW-1:0] TIMEOUT_C    = CW'(TIMEOUT_TICKS);
    localparam logic [CW-1:0] HOLDOFF_C    = CW'(HOLDOFF_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HI,
        S_BURST,
        S_ECHO,
        S_HOLDOFF
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [CW-1:0] width, width_nx;
    logic [CW-1:0] width_calc;
    logic [8:0]    last_cm_nx;
    logic          echo_nx, busy_nx, trig_err_nx;
    logic          accept;
    logic          in_range;
    logic [3:0]    jitter;

    logic          trig_meta, trig_s, trig_s_d;
    logic [2:0]    sync_vld;
    logic          trig_rise;

    // sync_vld masks the false rise that the zeroed synchronizer would
    // otherwise report when trig is held high across reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
            trig_s_d  <= 1'b0;
            sync_vld  <= '0;
        end else begin
            trig_meta <= trig;
            trig_s    <= trig_meta;
            trig_s_d  <= trig_s;
            sync_vld  <= {sync_vld[1:0], 1'b1};
        end
    end

    assign trig_rise = sync_vld[2] & trig_s & ~trig_s_d;

`ifdef ECHO_JITTER_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign jitter = lfsr[3:0];
`else
    assign jitter = 4'd0;
`endif

    assign in_range   = (dist_cm != 9'd0) && (32'(dist_cm) <= 32'(MAX_CM));
    assign width_calc = in_range ? CW'(32'(dist_cm) * TICKS_PER_CM + 32'(jitter))
                                 : TIMEOUT_C;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        width_nx    = width;
        last_cm_nx  = last_cm;
        echo_nx     = 1'b0;
        trig_err_nx = 1'b0;
        accept      = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (trig_rise && en) begin
                    state_nx = S_TRIG_HI;
                    cnt_nx   = CW'(1);
                end
            end
            S_TRIG_HI: begin
                if (trig_s) begin
                    if (cnt < TRIG_MIN_C) begin
                        cnt_nx = cnt + CW'(1);
                    end
                end else if (cnt >= TRIG_MIN_C) begin
                    state_nx   = S_BURST;
                    cnt_nx     = '0;
                    last_cm_nx = dist_cm;
                    width_nx   = width_calc;
                    accept     = 1'b1;
                end else begin
                    state_nx    = S_IDLE;
                    cnt_nx      = '0;
                    trig_err_nx = 1'b1;
                end
            end
            S_BURST: begin
                if (cnt == BURST_LAST_C) begin
                    state_nx = S_ECHO;
                    cnt_nx   = CW'(1);
                    echo_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_ECHO: begin
                if (cnt >= width) begin
                    state_nx = S_HOLDOFF;
                    cnt_nx   = CW'(1);
                end else begin
                    cnt_nx  = cnt + CW'(1);
                    echo_nx = 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (cnt >= HOLDOFF_C) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            width    <= '0;
            last_cm  <= '0;
            echo     <= 1'b0;
            busy     <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            width    <= width_nx;
            last_cm  <= last_cm_nx;
            echo     <= echo_nx;
            busy     <= busy_nx;
            trig_err <= trig_err_nx;
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed bench for ultrasonic_echo_emulator with shrunk tick parameters.
module tb_ultrasonic_echo_emulator;

    localparam int TMIN = 5;
    localparam int BD   = 20;
    localparam int TPC  = 3;
    localparam int MAXC = 400;
    localparam int TO   = 1500;
    localparam int HO   = 30;
    localparam int LAT  = BD + 2;   // two synchronizer stages before the fall is seen
    localparam int LIM  = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       trig = 1'b0;
    logic [8:0] dist_cm = 9'd0;
    logic       echo, busy, trig_err;
    logic [8:0] last_cm;

    int total = 0;
    int bad = 0;
`ifdef ECHO_JITTER_EN
    logic [7:0] mlfsr = 8'hA5;
`endif

    always #5 clk = ~clk;

    ultrasonic_echo_emulator #(
        .TRIG_MIN_TICKS   (TMIN),
        .BURST_DELAY_TICKS(BD),
        .TICKS_PER_CM     (TPC),
        .MAX_CM           (MAXC),
        .TIMEOUT_TICKS    (TO),
        .HOLDOFF_TICKS    (HO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .trig    (trig),
        .dist_cm (dist_cm),
        .echo    (echo),
        .busy    (busy),
        .trig_err(trig_err),
        .last_cm (last_cm)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_w(input int d, output int w);
        w = (d >= 1 && d <= MAXC) ? d * TPC : TO;
`ifdef ECHO_JITTER_EN
        if (d >= 1 && d <= MAXC) w += int'(mlfsr[3:0]);
        mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
`endif
    endtask

    task automatic pulse_trig(input int n);
        @(negedge clk);
        trig = 1'b1;
        repeat (n) @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_rise(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!echo && lat < LIM);
    endtask

    task automatic wait_fall(output int wid);
        wid = 0;
        while (echo && wid < LIM) begin
            wid++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(output int cyc, output int errs);
        cyc = 0;
        errs = 0;
        while (busy && cyc < LIM) begin
            @(posedge clk);
            #1;
            cyc++;
            if (trig_err) errs++;
        end
    endtask

    task automatic watch(input int n, output int echo_n, output int busy_n,
                         output int err_n, output int first_err);
        echo_n = 0;
        busy_n = 0;
        err_n = 0;
        first_err = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (echo) echo_n++;
            if (busy) busy_n++;
            if (trig_err) begin
                err_n++;
                if (first_err == 0) first_err = i;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat, wid, cyc, errs, en_n, bn, ern, fe;
        int dl[6];
        dl = '{0, 401, 400, 1, 1, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_echo", echo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", trig_err, 0);
        chk("reset_last_cm", last_cm, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Nominal 100 cm echo; dist_cm change after latching must not matter.
        dist_cm = 9'd100;
        expect_w(100, w);
        pulse_trig(TMIN);
        wait_rise(lat);
        chk("d100_latency", lat, LAT);
        chk("d100_busy", busy, 1);
        chk("d100_last_cm", last_cm, 100);
        dist_cm = 9'd7;
        wait_fall(wid);
        chk("d100_width", wid, w);
        chk("d100_last_cm_hold", last_cm, 100);
        wait_idle(cyc, errs);
        chk("d100_holdoff", cyc, HO);

        // Trigger one cycle too short.
        pulse_trig(TMIN - 1);
        watch(60, en_n, bn, ern, fe);
        chk("short_err_count", ern, 1);
        chk("short_err_cycle", fe, 3);
        chk("short_no_echo", en_n, 0);
        chk("short_busy_end", busy, 0);

        // Out-of-range, boundary and minimum distances; en dropped mid-cycle.
        foreach (dl[k]) begin
            dist_cm = 9'(dl[k]);
            expect_w(dl[k], w);
            pulse_trig(TMIN);
            en = 1'b0;
            wait_rise(lat);
            chk($sformatf("d%0d_latency", dl[k]), lat, LAT);
            wait_fall(wid);
            chk($sformatf("d%0d_width", dl[k]), wid, w);
            chk($sformatf("d%0d_last_cm", dl[k]), last_cm, dl[k]);
            wait_idle(cyc, errs);
            en = 1'b1;
        end

        // Triggers during ECHO and HOLDOFF are ignored.
        dist_cm = 9'd10;
        expect_w(10, w);
        pulse_trig(TMIN);
        wait_rise(lat);
        chk("ign_latency", lat, LAT);
        pulse_trig(6);
        wait_fall(wid);
        chk("ign_echo_rest", wid, w - 6);
        pulse_trig(4);
        wait_idle(cyc, errs);
        chk("ign_holdoff_rest", cyc, HO - 4);
        chk("ign_holdoff_err", errs, 0);
        expect_w(10, w);
        pulse_trig(TMIN);
        wait_rise(lat);
        chk("ign_next_latency", lat, LAT);
        wait_fall(wid);
        chk("ign_next_width", wid, w);
        wait_idle(cyc, errs);

        // en low in IDLE: no response.
        en = 1'b0;
        pulse_trig(TMIN);
        watch(60, en_n, bn, ern, fe);
        chk("en0_echo", en_n, 0);
        chk("en0_busy", bn, 0);
        chk("en0_err", ern, 0);
        en = 1'b1;

        // Reset during ECHO with trig held high across it.
        dist_cm = 9'd50;
        expect_w(50, w);
        pulse_trig(TMIN);
        wait_rise(lat);
        chk("rst_pre_latency", lat, LAT);
        @(negedge clk);
        trig = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_echo", echo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last_cm", last_cm, 0);
`ifdef ECHO_JITTER_EN
        mlfsr = 8'hA5;
`endif
        @(negedge clk);
        rst = 1'b0;
        watch(40, en_n, bn, ern, fe);
        chk("rst_held_echo", en_n, 0);
        chk("rst_held_busy", bn, 0);
        @(negedge clk);
        trig = 1'b0;
        dist_cm = 9'd20;
        expect_w(20, w);
        pulse_trig(TMIN);
        wait_rise(lat);
        chk("post_rst_latency", lat, LAT);
        wait_fall(wid);
        chk("post_rst_width", wid, w);
        chk("post_rst_last_cm", last_cm, 20);
        wait_idle(cyc, errs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
